// File: rtl/seg_scan_sequencer_pkg.sv
// Shared types and constants for the 7-segment scan sequencer:
// the fetch/scan state encodings and the display geometry.
package seg_scan_sequencer_pkg;

  localparam int DIGITS   = 4;
  localparam int NIBBLE_W = 4;
  localparam int DIGIT_W  = $clog2(DIGITS);

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,
    F_WAIT = 2'd1,
    F_LOAD = 2'd2
  } fetch_state_t;

  typedef enum logic {
    S_DRIVE = 1'b0,
    S_BLANK = 1'b1
  } scan_state_t;

endpackage

// File: rtl/seg_scan_sequencer_if.sv
// Tick, ROM and display-pin bundle between the sequencer and its surroundings.
// The slave side is the sequencer; the master side drives ticks and ROM data.
interface seg_scan_sequencer_if
  import seg_scan_sequencer_pkg::*;
#(
  parameter int ADDR_W = 4
);

  logic                      step_tick;
  logic                      scan_tick;
  logic                      pause;
  logic [DIGITS*NIBBLE_W-1:0] rom_q;
  logic [ADDR_W-1:0]         rom_addr;
  logic [NIBBLE_W-1:0]       hex_out;
  logic [DIGITS-1:0]         digit_en;
  logic                      data_valid;
  logic                      frame_done;

  modport master (
    output step_tick, scan_tick, pause, rom_q,
    input  rom_addr, hex_out, digit_en, data_valid, frame_done
  );

  modport slave (
    input  step_tick, scan_tick, pause, rom_q,
    output rom_addr, hex_out, digit_en, data_valid, frame_done
  );

endinterface

// File: rtl/seg_scan_mux.sv
// Digit scan engine: walks the four nibbles of the display word onto one
// decoder, with one-hot digit enables and a blanking dead-time between digits.
module seg_scan_mux
  import seg_scan_sequencer_pkg::*;
#(
  parameter int DEAD_CYCLES   = 4,
  parameter int EN_ACTIVE_LOW = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_scan_tick,
  input  logic                       i_data_valid,
  input  logic [DIGITS*NIBBLE_W-1:0] i_display,
  output logic [NIBBLE_W-1:0]        o_hex,
  output logic [DIGITS-1:0]          o_digit_en,
  output logic                       o_frame_done
);

  localparam logic [7:0] DEAD_LAST = 8'(DEAD_CYCLES - 1);

  scan_state_t        r_state, w_state_next;
  logic [DIGIT_W-1:0] r_digit, w_digit_next;
  logic [7:0]         r_dead_cnt, w_dead_cnt_next;
  logic               r_primed, w_primed_next;
  logic               r_frame_done, w_frame_done_next;

  logic [NIBBLE_W-1:0] w_nib [DIGITS];
  logic [DIGITS-1:0]   w_en_raw;

  // Reset parks in the blank that precedes digit 0; r_primed keeps that
  // first wrap from being reported as a completed frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_BLANK;
      r_digit      <= DIGIT_W'(DIGITS - 1);
      r_dead_cnt   <= '0;
      r_primed     <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_digit      <= w_digit_next;
      r_dead_cnt   <= w_dead_cnt_next;
      r_primed     <= w_primed_next;
      r_frame_done <= w_frame_done_next;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_digit_next      = r_digit;
    w_dead_cnt_next   = r_dead_cnt;
    w_primed_next     = r_primed;
    w_frame_done_next = 1'b0;
    case (r_state)
      S_DRIVE: begin
        if (i_scan_tick) begin
          w_state_next    = S_BLANK;
          w_dead_cnt_next = '0;
        end
      end
      S_BLANK: begin
        if (r_dead_cnt == DEAD_LAST) begin
          w_state_next      = S_DRIVE;
          w_digit_next      = r_digit + 1'b1;
          w_primed_next     = 1'b1;
          w_frame_done_next = r_primed && (r_digit == DIGIT_W'(DIGITS - 1));
        end else begin
          w_dead_cnt_next = r_dead_cnt + 1'b1;
        end
      end
      default: w_state_next = S_BLANK;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < DIGITS; gi++) begin : g_digit
      assign w_nib[gi]    = i_display[gi*NIBBLE_W +: NIBBLE_W];
      assign w_en_raw[gi] = (r_state == S_DRIVE) && i_data_valid &&
                            (r_digit == DIGIT_W'(gi));
    end
  endgenerate

  assign o_hex        = w_nib[r_digit];
  assign o_digit_en   = (EN_ACTIVE_LOW != 0) ? ~w_en_raw : w_en_raw;
  assign o_frame_done = r_frame_done;

endmodule

// File: rtl/seg_scan_sequencer.sv
// Steps the pattern ROM address, waits out the ROM latency, captures the word
// into the display register and hands it to the digit scan engine.
module seg_scan_sequencer
  import seg_scan_sequencer_pkg::*;
#(
  parameter int ADDR_W        = 4,
  parameter int ROM_LATENCY   = 2,
  parameter int DEAD_CYCLES   = 4,
  parameter int EN_ACTIVE_LOW = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  seg_scan_sequencer_if.slave  bus
);

  localparam logic [2:0] LAT_LAST = 3'(ROM_LATENCY - 1);

  fetch_state_t               r_state, w_state_next;
  logic [ADDR_W-1:0]          r_addr, w_addr_next;
  logic [2:0]                 r_lat_cnt, w_lat_cnt_next;
  logic                       r_pending, w_pending_next;
  logic [DIGITS*NIBBLE_W-1:0] r_display, w_display_next;
  logic                       r_valid, w_valid_next;
  logic                       w_step;

  assign w_step = bus.step_tick & ~bus.pause;

  // Reset lands in WAIT so address 0 is fetched without needing a step.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= F_WAIT;
      r_addr    <= '0;
      r_lat_cnt <= '0;
      r_pending <= 1'b0;
      r_display <= '0;
      r_valid   <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_addr    <= w_addr_next;
      r_lat_cnt <= w_lat_cnt_next;
      r_pending <= w_pending_next;
      r_display <= w_display_next;
      r_valid   <= w_valid_next;
    end
  end

  always_comb begin
    w_state_next   = r_state;
    w_addr_next    = r_addr;
    w_lat_cnt_next = r_lat_cnt;
    w_pending_next = r_pending;
    w_display_next = r_display;
    w_valid_next   = r_valid;
    case (r_state)
      F_IDLE: begin
        if (w_step) begin
          w_addr_next    = r_addr + 1'b1;
          w_lat_cnt_next = '0;
          w_state_next   = F_WAIT;
        end
      end
      F_WAIT: begin
        if (w_step) begin
          w_pending_next = 1'b1;
        end
        if (r_lat_cnt == LAT_LAST) begin
          w_state_next = F_LOAD;
        end else begin
          w_lat_cnt_next = r_lat_cnt + 1'b1;
        end
      end
      F_LOAD: begin
        w_display_next = bus.rom_q;
        w_valid_next   = 1'b1;
        // A step arriving in this very cycle counts as pending too.
        if (r_pending || w_step) begin
          w_addr_next    = r_addr + 1'b1;
          w_lat_cnt_next = '0;
          w_pending_next = 1'b0;
          w_state_next   = F_WAIT;
        end else begin
          w_state_next = F_IDLE;
        end
      end
      default: w_state_next = F_IDLE;
    endcase
  end

  seg_scan_mux #(
    .DEAD_CYCLES   (DEAD_CYCLES),
    .EN_ACTIVE_LOW (EN_ACTIVE_LOW)
  ) u_mux (
    .clk          (clk),
    .rst          (rst),
    .i_scan_tick  (bus.scan_tick),
    .i_data_valid (r_valid),
    .i_display    (r_display),
    .o_hex        (bus.hex_out),
    .o_digit_en   (bus.digit_en),
    .o_frame_done (bus.frame_done)
  );

  assign bus.rom_addr   = r_addr;
  assign bus.data_valid = r_valid;

endmodule

// File: tb/tb_seg_scan_sequencer.sv
// Directed bench for seg_scan_sequencer: an active-high and an active-low
// instance run side by side against a two-stage ROM model.
module tb_seg_scan_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  logic [15:0] rom_words [16] = '{
    16'h1234, 16'hA5C5, 16'h0F06, 16'hBEE7, 16'hC0D8, 16'h1119, 16'h222A, 16'h333B,
    16'h444C, 16'h555D, 16'h666E, 16'h777F, 16'h8880, 16'h9991, 16'hAAA2, 16'hBBB3
  };
  logic [15:0] rom_p1, rom_p2;

  always #5 clk = ~clk;

  seg_scan_sequencer_if #(.ADDR_W(4)) if0 ();
  seg_scan_sequencer_if #(.ADDR_W(4)) if1 ();

  seg_scan_sequencer #(.ADDR_W(4), .ROM_LATENCY(2), .DEAD_CYCLES(4), .EN_ACTIVE_LOW(0))
    dut0 (.clk(clk), .rst(rst), .bus(if0));
  seg_scan_sequencer #(.ADDR_W(4), .ROM_LATENCY(2), .DEAD_CYCLES(4), .EN_ACTIVE_LOW(1))
    dut1 (.clk(clk), .rst(rst), .bus(if1));

  // ROM with two cycles from address change to valid data.
  always @(posedge clk) begin
    rom_p1 <= rom_words[if0.rom_addr];
    rom_p2 <= rom_p1;
  end
  assign if0.rom_q     = rom_p2;
  assign if1.rom_q     = rom_p2;
  assign if1.step_tick = if0.step_tick;
  assign if1.scan_tick = if0.scan_tick;
  assign if1.pause     = if0.pause;

  task automatic check_vec(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic check_en(input string tag, input logic [3:0] exp);
    logic [3:0] inv;
    inv = ~exp;
    check_vec(tag, 16'(if0.digit_en), 16'(exp));
    check_vec({tag, "_n"}, 16'(if1.digit_en), 16'(inv));
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_step();
    if0.step_tick = 1'b1;
    cyc(1);
    if0.step_tick = 1'b0;
  endtask

  initial begin
    logic [15:0] w;
    logic [3:0]  nib;
    int          d;

    if0.step_tick = 1'b0;
    if0.scan_tick = 1'b0;
    if0.pause     = 1'b0;
    cyc(3);
    check_vec("rst_addr", 16'(if0.rom_addr), 16'h0);
    check_en("rst_en", 4'b0000);
    check_vec("rst_dv", 16'(if0.data_valid), 16'h0);
    check_vec("rst_fd", 16'(if0.frame_done), 16'h0);
    check_vec("rst_hex", 16'(if0.hex_out), 16'h0);

    // First fetch of word 0 after reset release.
    rst = 1'b0;
    cyc(1); check_vec("dv_c1", 16'(if0.data_valid), 16'h0);
    cyc(1); check_vec("dv_c2", 16'(if0.data_valid), 16'h0);
    cyc(1); check_vec("dv_c3", 16'(if0.data_valid), 16'h1);
    check_en("en_c3_blank", 4'b0000);
    cyc(1);
    check_en("en_d0", 4'b0001);
    check_vec("hex_d0", 16'(if0.hex_out), 16'h4);
    check_vec("fd_d0", 16'(if0.frame_done), 16'h0);

    // Four digit advances; the last one wraps and ends the frame.
    w = rom_words[0];
    for (int k = 0; k < 4; k++) begin
      if0.scan_tick = 1'b1;
      cyc(1);
      if0.scan_tick = 1'b0;
      check_en("blank0", 4'b0000);
      for (int j = 1; j < 4; j++) begin
        if (k == 1 && j == 1) if0.scan_tick = 1'b1;
        cyc(1);
        if0.scan_tick = 1'b0;
        check_en("blank", 4'b0000);
      end
      cyc(1);
      d   = (k + 1) % 4;
      nib = 4'(w >> (4 * d));
      check_en("drive_en", 4'(1 << d));
      check_vec("drive_hex", 16'(if0.hex_out), 16'(nib));
      check_vec("drive_fd", 16'(if0.frame_done), (k == 3) ? 16'h1 : 16'h0);
      if (k == 3) begin
        cyc(1);
        check_vec("fd_drop", 16'(if0.frame_done), 16'h0);
        check_en("en_hold", 4'b0001);
      end
    end

    // Sixteen spaced steps, including the 15 -> 0 wrap.
    for (int i = 0; i < 16; i++) begin
      pulse_step();
      check_vec("step_addr", 16'(if0.rom_addr), 16'((i + 1) % 16));
      cyc(2);
      w = rom_words[i];
      check_vec("step_old", 16'(if0.hex_out), 16'(w[3:0]));
      cyc(1);
      w = rom_words[(i + 1) % 16];
      check_vec("step_new", 16'(if0.hex_out), 16'(w[3:0]));
      cyc(6);
    end

    // Three back-to-back ticks: one advance, one pending, one dropped.
    if0.step_tick = 1'b1;
    cyc(1);
    check_vec("burst_a1", 16'(if0.rom_addr), 16'h1);
    cyc(2);
    if0.step_tick = 1'b0;
    check_vec("burst_a1b", 16'(if0.rom_addr), 16'h1);
    cyc(1);
    check_vec("burst_a2", 16'(if0.rom_addr), 16'h2);
    cyc(10);
    check_vec("burst_final", 16'(if0.rom_addr), 16'h2);
    check_vec("burst_hex", 16'(if0.hex_out), 16'h6);

    // Paused ticks are ignored.
    if0.pause = 1'b1;
    repeat (5) begin
      pulse_step();
      cyc(2);
    end
    check_vec("pause_addr", 16'(if0.rom_addr), 16'h2);
    if0.pause = 1'b0;
    pulse_step();
    check_vec("unpause_addr", 16'(if0.rom_addr), 16'h3);
    cyc(5);
    check_vec("unpause_hex", 16'(if0.hex_out), 16'h7);

    // Walk to address 7, then reset while its fetch is still waiting.
    repeat (3) begin
      pulse_step();
      cyc(9);
    end
    pulse_step();
    check_vec("pre_rst_addr", 16'(if0.rom_addr), 16'h7);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    check_vec("mrst_addr", 16'(if0.rom_addr), 16'h0);
    check_en("mrst_en", 4'b0000);
    check_vec("mrst_dv", 16'(if0.data_valid), 16'h0);
    check_vec("mrst_hex", 16'(if0.hex_out), 16'h0);
    cyc(2);
    check_vec("mrst_dv_c2", 16'(if0.data_valid), 16'h0);
    cyc(1);
    check_vec("mrst_dv_c3", 16'(if0.data_valid), 16'h1);
    cyc(1);
    check_en("mrst_en_d0", 4'b0001);
    check_vec("mrst_hex_d0", 16'(if0.hex_out), 16'h4);
    check_vec("mrst_fd", 16'(if0.frame_done), 16'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/seg_scan_sequencer.md
Name: seg_scan_sequencer

Overview:
Controller for the 4-digit 7-segment display path. It steps the 16-bit pattern ROM address, waits out the ROM read latency, and captures the word into a display register. It then time-multiplexes the four nibbles onto one hex2seg decoder, with one-hot digit enables and a blanking dead-time between digits. It sits between the tick generators (time_counter outputs, used here as clk-domain enables) and the ROM / hex2seg / DS_EN pins.

Parameters:
ADDR_W, 4, ROM address width; ROM depth = 2**ADDR_W
ROM_LATENCY, 2, clk cycles from rom_addr change to valid rom_q (range 1..7)
DEAD_CYCLES, 4, clk cycles with all digits off between digits (range 1..255)
EN_ACTIVE_LOW, 0, 1 = digit_en output inverted at the port

Ports:
clk  in  1  system clock; all logic on rising edge
rst  in  1  synchronous reset, active-high
step_tick  in  1  one-cycle pulse: advance ROM address
scan_tick  in  1  one-cycle pulse: advance to next digit
pause  in  1  level: 1 = step_tick ignored (scan continues)
rom_q  in  16  ROM read data
rom_addr  out  ADDR_W  ROM address (registered)
hex_out  out  4  nibble for current digit, to hex2seg
digit_en  out  4  one-hot digit enable (bit0 = least-significant nibble), all-off during blanking
data_valid  out  1  1 once the first ROM word after reset has been captured
frame_done  out  1  one-cycle pulse at end of digit 3's blanking interval

Behaviour:
- Reset values: rom_addr=0, hex_out=0, digit_en=all off (respecting EN_ACTIVE_LOW), data_valid=0, frame_done=0, display_reg=0, scan FSM in BLANK for digit 0, fetch FSM in WAIT with latency counter=0. Result: address 0 is fetched automatically after reset.
- Fetch FSM, states IDLE, WAIT, LOAD:
  - IDLE: on step_tick && !pause, rom_addr <= rom_addr+1 (wraps 2**ADDR_W-1 -> 0), counter cleared, go to WAIT.
  - WAIT: count ROM_LATENCY cycles, then go to LOAD.
  - LOAD: display_reg <= rom_q, data_valid <= 1, go to IDLE, or go directly to WAIT if a step is pending.
- step_tick arriving in WAIT/LOAD with !pause sets a 1-deep pending flag; further ticks while pending are dropped. The pending step advances the address on leaving LOAD, counter cleared.
- pause=1 at tick time suppresses both the advance and setting of pending. An already-pending step still executes.
- Display register changes only in LOAD, so a digit never shows a partially updated word.
- Scan FSM, states DRIVE, BLANK, with digit index d in 0..3:
  - DRIVE: digit_en = one-hot(d), hex_out = display_reg[4d+3:4d].
  - DRIVE, scan_tick: go to BLANK, digit_en off next cycle.
  - BLANK: count DEAD_CYCLES, then d <= d+1 (3 -> 0) and go to DRIVE. hex_out is updated on the same edge as digit_en.
  - frame_done pulses on the BLANK->DRIVE edge where d wraps 3->0.
  - scan_tick during BLANK is ignored.
- Before data_valid=1, the scan still runs but digit_en is forced all-off.
- step_tick and scan_tick in the same cycle: both FSMs act independently.
- rst mid-operation: all state returns to reset values on that edge. The fetch in progress is abandoned and address 0 is refetched.
- Latency:
  - step_tick at cycle n: rom_addr changes at n+1.
  - display_reg is updated at n+2+ROM_LATENCY.
  - The new value reaches hex_out at the next DRIVE entry or on the same cycle if in DRIVE.

Decomposition:
- Shared package:
  - fetch state enum (IDLE/WAIT/LOAD)
  - scan state enum (DRIVE/BLANK)
  - DIGITS=4, NIBBLE_W=4 constants
- One natural sub-module: seg_scan_mux, holding the scan FSM, dead-time counter, nibble select and enable polarity. The fetch FSM stays in the top.

Test Plan:
- Reset release, ROM model latency 2 with word[0]=16'h1234:
  - data_valid rises 3 cycles after rst falls.
  - After 4 scan_ticks (DEAD_CYCLES=4), hex_out sequence is 4,3,2,1 with digit_en 0001,0010,0100,1000.
- Pulse step_tick 16 times, spaced 10 cycles, pause=0 -> rom_addr goes 1..15 then 0; display_reg equals word[addr] each time.
- step_tick on 3 consecutive cycles from IDLE -> exactly 2 address advances (one immediate, one pending), the third is dropped; final rom_addr=2.
- pause=1 with 5 step_ticks -> rom_addr unchanged. Deassert pause, one tick -> rom_addr+1.
- DEAD_CYCLES=4, scan_tick on digit 3 -> digit_en all-off for exactly 4 cycles, then 0001; frame_done high for exactly that one cycle. EN_ACTIVE_LOW=1 -> same sequence inverted (1111 during blank, 1110 on digit 0).
- Assert rst for one cycle during WAIT at rom_addr=7 -> next cycle rom_addr=0, digit_en off, data_valid=0; refetch of word[0] completes normally.
